// File: rtl/dcache_ctrl.sv
// Blocking write-through / no-write-allocate data-cache controller.
// Stalls the core while a read-miss refill or a store write-through is in flight.
module dcache_ctrl #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              hit,
    output logic              stall,
    output logic              cache_we,
    output logic              refill_we,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              busy,
    output logic [PERF_W-1:0] miss_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE_MEM,
        DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_rd_en;
    logic              r_mem_wr_en;
    logic              r_busy;
    logic [PERF_W-1:0] r_miss_count;

    logic w_take_write;
    logic w_take_miss;
    logic w_last;

    // A simultaneous read and write resolves to the write.
    assign w_take_write = mem_write;
    assign w_take_miss  = mem_read & ~mem_write & ~hit;
    assign w_last       = (r_cnt == LAST_CNT);

    // Memory enables and busy are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_busy       <= 1'b0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_take_write) begin
                        r_state     <= WRITE_MEM;
                        r_mem_wr_en <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (w_take_miss) begin
                        r_state     <= READ_MISS;
                        r_mem_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + PERF_W'(1);
                        end
                    end
                end
                READ_MISS: begin
                    if (w_last) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_mem_rd_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WRITE_MEM: begin
                    if (w_last) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_mem_wr_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_mem_rd_en <= 1'b0;
                    r_mem_wr_en <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Cache write strobes are suppressed while reset is asserted.
    always_comb begin
        stall     = 1'b0;
        cache_we  = 1'b0;
        refill_we = 1'b0;
        case (r_state)
            IDLE: begin
                stall    = w_take_write | w_take_miss;
                cache_we = w_take_write & hit & ~rst;
            end
            READ_MISS: begin
                stall     = 1'b1;
                refill_we = w_last & ~rst;
            end
            WRITE_MEM: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    assign mem_rd_en  = r_mem_rd_en;
    assign mem_wr_en  = r_mem_wr_en;
    assign busy       = r_busy;
    assign miss_count = r_miss_count;

endmodule
